// File: rtl/cache_line_responder_if.sv
// Line-fill bus between a cache (master) and its backing-memory responder (slave):
// request handshake, response beats and a single-word write port.
interface cache_line_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_addr;

  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic [1:0]  rsp_word;
  logic        rsp_last;

  logic        wr_en;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;

  modport slave (
    input  req_valid, req_addr, wr_en, wr_addr, wr_data,
    output req_ready, rsp_valid, rsp_data, rsp_word, rsp_last
  );

  modport master (
    output req_valid, req_addr, wr_en, wr_addr, wr_data,
    input  req_ready, rsp_valid, rsp_data, rsp_word, rsp_last
  );
endinterface

// File: rtl/cache_line_responder.sv
// Backing word RAM that answers cache line fills with four paced 16-bit beats.
// Define CRITICAL_WORD_FIRST_EN to start each burst at the requested word and wrap.
module cache_line_responder #(
  parameter int MEM_AW      = 10,
  parameter int WAIT_CYCLES = 3,
  parameter     INIT_FILE   = ""
) (
  input  logic                   clk_100,
  input  logic                   rst_n,
  cache_line_responder_if.slave  bus
);

  localparam int DEPTH = 2 ** MEM_AW;
  localparam int CW    = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int LW    = MEM_AW - 2;
  localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_BEAT
  } state_e;

  logic [15:0] mem [DEPTH];

  state_e          state_q,     state_d;
  logic            req_ready_q, req_ready_d;
  logic [LW-1:0]   line_q,      line_d;
  logic [1:0]      base_q,      base_d;
  logic [1:0]      beat_q,      beat_d;
  logic [CW-1:0]   wait_cnt_q,  wait_cnt_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [15:0]     rsp_data_q,  rsp_data_d;
  logic [1:0]      rsp_word_q,  rsp_word_d;
  logic            rsp_last_q,  rsp_last_d;

  logic [1:0]        rd_word;
  logic [MEM_AW-1:0] rd_idx;
  logic [15:0]       rd_data;
  logic              launch;

  // Address bits above the RAM depth are deliberately ignored.
  logic unused_addr_bits;
`ifdef CRITICAL_WORD_FIRST_EN
  assign unused_addr_bits = ^{bus.req_addr[15:MEM_AW], bus.wr_addr[15:MEM_AW]};
`else
  assign unused_addr_bits = ^{bus.req_addr[15:MEM_AW], bus.req_addr[1:0],
                              bus.wr_addr[15:MEM_AW]};
`endif

  // NOTE: the RAM array has no reset; contents survive rst_n, and leaving reset off keeps it mappable to block RAM.
  always_ff @(posedge clk_100) begin
    if (bus.wr_en) mem[bus.wr_addr[MEM_AW-1:0]] <= bus.wr_data;
  end

  // beat_q always names the next beat to launch, so the read index is ready before the launch edge.
  always_comb begin
    rd_word = base_q + beat_q;
    rd_idx  = {line_q, rd_word};
    rd_data = mem[rd_idx];
    launch  = ((state_q == S_WAIT) && (wait_cnt_q == WAIT_LAST)) ||
              ((state_q == S_BEAT) && !rsp_last_q && (WAIT_CYCLES == 0));
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    line_d      = line_q;
    base_d      = base_q;
    beat_d      = beat_q;
    wait_cnt_d  = wait_cnt_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_word_d  = rsp_word_q;
    rsp_last_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        req_ready_d = 1'b1;
        if (req_ready_q && bus.req_valid) begin
          line_d      = bus.req_addr[MEM_AW-1:2];
`ifdef CRITICAL_WORD_FIRST_EN
          base_d      = bus.req_addr[1:0];
`else
          base_d      = 2'd0;
`endif
          beat_d      = 2'd0;
          wait_cnt_d  = '0;
          req_ready_d = 1'b0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!launch) wait_cnt_d = wait_cnt_q + CW'(1);
      end
      S_BEAT: begin
        if (rsp_last_q) begin
          req_ready_d = 1'b1;
          state_d     = S_IDLE;
        end else if (WAIT_CYCLES != 0) begin
          // The beat cycle itself counts as the first idle cycle of the next period.
          wait_cnt_d = CW'(1);
          state_d    = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Read-before-write: rd_data is sampled at the same edge a write lands, so it sees the old word.
    if (launch) begin
      state_d     = S_BEAT;
      rsp_valid_d = 1'b1;
      rsp_data_d  = rd_data;
      rsp_word_d  = rd_word;
      rsp_last_d  = (beat_q == 2'd3);
      beat_d      = beat_q + 2'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update from pre-edge values.
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b0;
      line_q      <= '0;
      base_q      <= 2'd0;
      beat_q      <= 2'd0;
      wait_cnt_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 16'h0000;
      rsp_word_q  <= 2'd0;
      rsp_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      line_q      <= line_d;
      base_q      <= base_d;
      beat_q      <= beat_d;
      wait_cnt_q  <= wait_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_word_q  <= rsp_word_d;
      rsp_last_q  <= rsp_last_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_word  = rsp_word_q;
  assign bus.rsp_last  = rsp_last_q;

endmodule

// File: tb/tb_cache_line_responder.sv
// Bench for cache_line_responder: two instances (WAIT_CYCLES=3 and 0) share writes and are
// checked every cycle against a timeline-based reference model of expected beats.
module tb_cache_line_responder;

  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic clk_100 = 1'b0;
  logic rst_n   = 1'b0;
  always #5 clk_100 = ~clk_100;

  cache_line_responder_if b3 ();
  cache_line_responder_if b0 ();

  cache_line_responder #(.MEM_AW(AW), .WAIT_CYCLES(3)) dut_w3 (
    .clk_100 (clk_100),
    .rst_n   (rst_n),
    .bus     (b3.slave)
  );

  cache_line_responder #(.MEM_AW(AW), .WAIT_CYCLES(0)) dut_w0 (
    .clk_100 (clk_100),
    .rst_n   (rst_n),
    .bus     (b0.slave)
  );

  typedef struct {
    int       d;
    int       t;
    int       idx;
    logic [1:0] word;
    bit       last;
  } beat_t;

  beat_t       exp_q[$];
  logic [15:0] mem_m [DEPTH];
  logic [15:0] obs_data [2][4];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  bit          out_rst = 1'b0;
  bit          rdy_m [2];
  int          last_launch [2];
  bit          req_v [2];
  logic [15:0] req_a [2];
  logic [15:0] last_req_addr = 16'h0040;
  logic        wr_en_v = 1'b0;
  logic [15:0] wr_addr_v = '0;
  logic [15:0] wr_data_v = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int wait_of(input int d);
    return (d == 0) ? 3 : 0;
  endfunction

  task automatic set_req(input int d, input bit v, input logic [15:0] a);
    req_v[d] = v;
    req_a[d] = a;
    if (v) last_req_addr = a;
    if (d == 0) begin b3.req_valid = v; b3.req_addr = a; end
    else        begin b0.req_valid = v; b0.req_addr = a; end
  endtask

  task automatic set_wr(input logic en, input logic [15:0] a, input logic [15:0] dat);
    wr_en_v = en; wr_addr_v = a; wr_data_v = dat;
    b3.wr_en = en; b3.wr_addr = a; b3.wr_data = dat;
    b0.wr_en = en; b0.wr_addr = a; b0.wr_data = dat;
  endtask

  task automatic get_rsp(input int d, output logic v, output logic [15:0] dat,
                         output logic [1:0] w, output logic l, output logic r);
    if (d == 0) begin v = b3.rsp_valid; dat = b3.rsp_data; w = b3.rsp_word; l = b3.rsp_last; r = b3.req_ready; end
    else        begin v = b0.rsp_valid; dat = b0.rsp_data; w = b0.rsp_word; l = b0.rsp_last; r = b0.req_ready; end
  endtask

  function automatic int pending(input int d);
    int n = 0;
    foreach (exp_q[i]) if (exp_q[i].d == d) n++;
    return n;
  endfunction

  // One clock: apply edge events to the model, compare, then commit the edge's write.
  task automatic step();
    logic        we, v, l, r;
    logic [15:0] wa, wd, dat;
    logic [1:0]  w;
    int          found, base, line, wc;
    string       sfx;
    we = wr_en_v; wa = wr_addr_v; wd = wr_data_v;
    @(posedge clk_100);
    cyc++;
    #1;
    if (rst_n) out_rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      sfx = (d == 0) ? "w3" : "w0";
      if (rst_n && req_v[d] && rdy_m[d]) begin
`ifdef CRITICAL_WORD_FIRST_EN
        base = int'(req_a[d][1:0]);
`else
        base = 0;
`endif
        line = int'(req_a[d]) / 4;
        for (int k = 0; k < 4; k++) begin
          beat_t b;
          wc     = (base + k) % 4;
          b.d    = d;
          b.t    = cyc + (k + 1) * (wait_of(d) + 1);
          b.word = 2'(wc);
          b.idx  = (line * 4 + wc) % DEPTH;
          b.last = (k == 3);
          exp_q.push_back(b);
        end
        set_req(d, 1'b0, req_a[d]);
      end
      get_rsp(d, v, dat, w, l, r);
      found = -1;
      foreach (exp_q[i]) if (exp_q[i].d == d && exp_q[i].t == cyc) found = i;
      if (found >= 0) begin
        check({"rsp_valid_", sfx}, v, 1);
        check({"rsp_data_", sfx}, dat, mem_m[exp_q[found].idx]);
        check({"rsp_word_", sfx}, w, exp_q[found].word);
        check({"rsp_last_", sfx}, l, exp_q[found].last);
        obs_data[d][exp_q[found].word] = dat;
        last_launch[d] = cyc;
        exp_q.delete(found);
      end else begin
        check({"rsp_idle_", sfx}, v, 0);
      end
      rdy_m[d] = out_rst && (pending(d) == 0) && (cyc > last_launch[d]);
      check({"req_ready_", sfx}, r, rdy_m[d]);
    end
    if (we) mem_m[int'(wa) % DEPTH] = wd;
  endtask

  task automatic assert_reset();
    logic v, l, r;
    logic [15:0] dat;
    logic [1:0] w;
    rst_n = 1'b0;
    set_req(0, 1'b0, 16'h0);
    set_req(1, 1'b0, 16'h0);
    set_wr(1'b0, 16'h0, 16'h0);
    #1;
    exp_q.delete();
    out_rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      rdy_m[d] = 1'b0;
      last_launch[d] = -1;
      get_rsp(d, v, dat, w, l, r);
      check("reset_outputs", {r, v, l, w, dat}, 0);
    end
  endtask

  task automatic issue(input int d, input logic [15:0] a);
    int n = 0;
    set_req(d, 1'b1, a);
    while (req_v[d] && n < 60) begin step(); n++; end
    check("accept_in_time", n < 60, 1);
  endtask

  task automatic wait_idle(input int d);
    int n = 0;
    while (!rdy_m[d] && n < 100) begin step(); n++; end
    check("idle_in_time", n < 100, 1);
  endtask

  initial begin
    logic [15:0] a;
    for (int d = 0; d < 2; d++) begin
      req_v[d] = 1'b0;
      req_a[d] = '0;
    end
    set_wr(1'b0, 16'h0, 16'h0);
    assert_reset();
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Preload every RAM word so any later read has a known expected value.
    for (int i = 0; i < DEPTH; i++) begin
      set_wr(1'b1, 16'(i), 16'($urandom));
      step();
    end
    for (int i = 0; i < 4; i++) begin
      set_wr(1'b1, 16'h0040 + 16'(i), 16'hA000 + 16'(i));
      step();
    end
    set_wr(1'b0, 16'h0, 16'h0);

    // Basic fill on both instances.
    set_req(0, 1'b1, 16'h0040);
    issue(1, 16'h0040);
    issue(0, 16'h0040);
    wait_idle(0);
    wait_idle(1);
    check("basic_beat3_w3", obs_data[0][3], 16'hA003);

    // Writes during the beat-1 wait: 0x42 is seen by beat 2, 0x40 leaves beat 0 untouched.
    issue(0, 16'h0040);
    repeat (4) step();
    set_wr(1'b1, 16'h0042, 16'hBEEF);
    step();
    set_wr(1'b1, 16'h0040, 16'h1234);
    step();
    set_wr(1'b0, 16'h0, 16'h0);
    wait_idle(0);
    check("wt_beat2", obs_data[0][2], 16'hBEEF);
    check("wt_beat0", obs_data[0][0], 16'hA000);

    // Back-to-back beats, critical word, and address wrap above the RAM depth.
    issue(1, 16'h0100);
    wait_idle(1);
    set_req(1, 1'b1, 16'h0043);
    issue(0, 16'h0043);
    wait_idle(0);
    wait_idle(1);
    issue(0, 16'hFC42);
    wait_idle(0);

    // Reset after beat 1 aborts the burst; a fresh request afterwards completes.
    issue(0, 16'h0040);
    repeat (8) step();
    assert_reset();
    repeat (3) step();
    rst_n = 1'b1;
    repeat (6) step();
    issue(0, 16'h0040);
    wait_idle(0);

    // Randomized traffic with writes aimed partly at the line in flight.
    for (int c = 0; c < 500; c++) begin
      for (int d = 0; d < 2; d++)
        if (!req_v[d] && $urandom_range(3) == 0) set_req(d, 1'b1, 16'($urandom));
      if ($urandom_range(2) == 0) begin
        a = ($urandom_range(1) == 0) ? 16'($urandom)
                                     : {last_req_addr[15:2], 2'($urandom)};
        set_wr(1'b1, a, 16'($urandom));
      end else begin
        set_wr(1'b0, 16'h0, 16'h0);
      end
      step();
    end
    set_wr(1'b0, 16'h0, 16'h0);
    for (int d = 0; d < 2; d++) if (req_v[d]) issue(d, req_a[d]);
    wait_idle(0);
    wait_idle(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
